min_sec_timebase: RTL and testbench

- Timebase and minutes/seconds stage of the alarm clock.
- Divides the system clock down to a 1 Hz tick and counts seconds 0–59 and minutes 0–59.
- Emits a single-cycle HourUp pulse on the 59:59→00:00 wrap; this pulse drives the up/enable input of the downstream 0–23 hours counter.
- Also provides a manual minute-set path and a colon-blink signal for the display.

---
 rtl/min_sec_timebase.sv | 104 ++++++++++
 tb/tb_min_sec_timebase.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/min_sec_timebase.sv
// rtl/min_sec_timebase.sv - 1 Hz timebase with seconds/minutes counters and HourUp carry
//
// Ports:
//   Clk      in   system clock, rising edge
//   Clr      in   asynchronous active-low reset
//   Enable   in   global enable; 0 freezes all counting state
//   Run      in   1 = timekeeping, 0 = set mode
//   SetMin   in   asynchronous push-button, advances MIN in set mode
//   ZeroSec  in   zeroes SEC and the prescaler on the next edge
//   SEC      out  seconds 0-59
//   MIN      out  minutes 0-59
//   HourUp   out  one-cycle pulse on the 59:59 -> 00:00 wrap
//   Tick     out  one-cycle pulse at each prescaler terminal count
//   HalfSec  out  high during the first half of each second (colon blink)

module min_sec_timebase #(
   parameter int TICK_DIV = 50000000,
   parameter int PW       = 26
) (
   input  logic       Clk,
   input  logic       Clr,
   input  logic       Enable,
   input  logic       Run,
   input  logic       SetMin,
   input  logic       ZeroSec,
   output logic [5:0] SEC,
   output logic [5:0] MIN,
   output logic       HourUp,
   output logic       Tick,
   output logic       HalfSec
);

   localparam logic [PW-1:0] TC_VAL   = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] HALF_VAL = PW'(TICK_DIV / 2);
   localparam logic [PW-1:0] PONE     = PW'(1);
   localparam logic [5:0]    LAST     = 6'd59;

   logic [PW-1:0] presc;
   logic          set_s1;
   logic          set_s2;
   logic          set_prev;
   logic          tc;
   logic          set_edge;

   assign tc       = (presc == TC_VAL);
   assign set_edge = set_s2 & ~set_prev;
   assign HalfSec  = (presc < HALF_VAL);

   // Synchroniser and edge register track the button regardless of Enable/Run,
   // so a press held across a mode change never produces a late edge.
   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         set_s1   <= 1'b0;
         set_s2   <= 1'b0;
         set_prev <= 1'b0;
      end else begin
         set_s1   <= SetMin;
         set_s2   <= set_s1;
         set_prev <= set_s2;
      end
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         presc  <= '0;
         SEC    <= 6'd0;
         MIN    <= 6'd0;
         HourUp <= 1'b0;
         Tick   <= 1'b0;
      end else if (!Enable) begin
         Tick   <= 1'b0;
         HourUp <= 1'b0;
      end else if (ZeroSec) begin
         // Takes priority over a coincident terminal count and any set edge.
         presc  <= '0;
         SEC    <= 6'd0;
         Tick   <= 1'b0;
         HourUp <= 1'b0;
      end else begin
         Tick   <= tc;
         HourUp <= 1'b0;
         presc  <= tc ? '0 : presc + PONE;
         if (Run) begin
            if (tc) begin
               if (SEC >= LAST) begin
                  SEC <= 6'd0;
                  if (MIN >= LAST) begin
                     MIN    <= 6'd0;
                     HourUp <= 1'b1;
                  end else begin
                     MIN <= MIN + 6'd1;
                  end
               end else begin
                  SEC <= SEC + 6'd1;
               end
            end
         end else if (set_edge) begin
            // Manual minute wrap never carries into the hours counter.
            MIN <= (MIN >= LAST) ? 6'd0 : MIN + 6'd1;
         end
      end
   end

endmodule

// File: tb/tb_min_sec_timebase.sv
// tb/tb_min_sec_timebase.sv - directed self-checking bench for min_sec_timebase

module tb_min_sec_timebase;

   logic       Clk = 1'b0;
   logic       Clr = 1'b0;
   logic       Enable = 1'b0;
   logic       Run = 1'b0;
   logic       SetMin = 1'b0;
   logic       ZeroSec = 1'b0;
   logic [5:0] SEC;
   logic [5:0] MIN;
   logic       HourUp;
   logic       Tick;
   logic       HalfSec;

   int checks = 0;
   int failures = 0;
   logic hu_seen = 1'b0;

   min_sec_timebase #(.TICK_DIV(4), .PW(3)) dut (
      .Clk(Clk), .Clr(Clr), .Enable(Enable), .Run(Run), .SetMin(SetMin),
      .ZeroSec(ZeroSec), .SEC(SEC), .MIN(MIN), .HourUp(HourUp),
      .Tick(Tick), .HalfSec(HalfSec)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         #1;
         hu_seen = hu_seen | HourUp;
      end
   endtask

   task automatic pulse_setmin(input int n);
      for (int i = 0; i < n; i++) begin
         SetMin = 1'b1;
         step(10);
         SetMin = 1'b0;
         step(10);
      end
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_sec", 32'(SEC), 0);
      chk("rst_min", 32'(MIN), 0);
      chk("rst_hourup", 32'(HourUp), 0);
      chk("rst_tick", 32'(Tick), 0);
      chk("rst_halfsec", 32'(HalfSec), 1);

      // basic timekeeping: 8 cycles -> SEC=2, tick every 4, halfsec 1,0,0,1...
      @(posedge Clk);
      #1;
      Clr = 1'b1;
      Run = 1'b1;
      Enable = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step(1);
         chk("run_tick", 32'(Tick), ((k % 4) == 0) ? 1 : 0);
         chk("run_halfsec", 32'(HalfSec), ((k % 4) < 2) ? 1 : 0);
      end
      chk("run_sec2", 32'(SEC), 2);
      chk("run_min0", 32'(MIN), 0);

      // set mode: 3-cycle SetMin latency
      Run = 1'b0;
      SetMin = 1'b1;
      step(2);
      chk("set_lat2_min", 32'(MIN), 0);
      step(1);
      chk("set_lat3_min", 32'(MIN), 1);
      step(7);
      SetMin = 1'b0;
      step(10);
      pulse_setmin(58);
      chk("set_min59", 32'(MIN), 59);
      chk("set_sec_frozen", 32'(SEC), 2);

      // zero seconds and run up to 59:58, 59:59
      ZeroSec = 1'b1;
      Run = 1'b1;
      step(1);
      ZeroSec = 1'b0;
      chk("zs_sec", 32'(SEC), 0);
      chk("zs_min", 32'(MIN), 59);
      chk("zs_tick", 32'(Tick), 0);
      chk("zs_halfsec", 32'(HalfSec), 1);
      step(232);
      chk("pre_sec58", 32'(SEC), 58);
      chk("pre_tick", 32'(Tick), 1);
      step(4);
      chk("pre_sec59", 32'(SEC), 59);
      chk("pre_min59", 32'(MIN), 59);
      chk("pre_hourup", 32'(HourUp), 0);

      // ZeroSec on the terminal-count cycle of 59:59
      step(3);
      chk("tc_halfsec", 32'(HalfSec), 0);
      ZeroSec = 1'b1;
      step(1);
      ZeroSec = 1'b0;
      chk("zstc_sec", 32'(SEC), 0);
      chk("zstc_min", 32'(MIN), 59);
      chk("zstc_hourup", 32'(HourUp), 0);
      chk("zstc_tick", 32'(Tick), 0);

      // full wrap 59:59 -> 00:00 with one-cycle HourUp
      step(236);
      chk("wrap_pre_sec", 32'(SEC), 59);
      chk("wrap_pre_min", 32'(MIN), 59);
      hu_seen = 1'b0;
      step(3);
      chk("wrap_no_early_hu", 32'(hu_seen), 0);
      step(1);
      chk("wrap_sec", 32'(SEC), 0);
      chk("wrap_min", 32'(MIN), 0);
      chk("wrap_hourup", 32'(HourUp), 1);
      chk("wrap_tick", 32'(Tick), 1);
      step(1);
      chk("wrap_hourup_drop", 32'(HourUp), 0);
      chk("wrap_tick_drop", 32'(Tick), 0);

      // 61 manual minute pulses from 0: wraps to 1, no HourUp
      Run = 1'b0;
      hu_seen = 1'b0;
      pulse_setmin(61);
      chk("set61_min", 32'(MIN), 1);
      chk("set61_sec", 32'(SEC), 0);
      chk("set61_no_hu", 32'(hu_seen), 0);

      // go to 12:34 and freeze with Enable=0 at prescaler phase 2
      pulse_setmin(11);
      chk("set_min12", 32'(MIN), 12);
      ZeroSec = 1'b1;
      Run = 1'b1;
      step(1);
      ZeroSec = 1'b0;
      step(136);
      chk("en_sec34", 32'(SEC), 34);
      step(2);
      chk("en_phase_halfsec", 32'(HalfSec), 0);
      Enable = 1'b0;
      hu_seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step(1);
         chk("dis_sec", 32'(SEC), 34);
         chk("dis_min", 32'(MIN), 12);
         chk("dis_tick", 32'(Tick), 0);
         chk("dis_halfsec", 32'(HalfSec), 0);
      end
      chk("dis_no_hu", 32'(hu_seen), 0);
      Enable = 1'b1;
      step(1);
      chk("resume1_tick", 32'(Tick), 0);
      chk("resume1_sec", 32'(SEC), 34);
      step(1);
      chk("resume2_tick", 32'(Tick), 1);
      chk("resume2_sec", 32'(SEC), 35);
      chk("resume2_halfsec", 32'(HalfSec), 1);

      // back to 59:00, run to the wrap, then asynchronous Clr during HourUp
      Run = 1'b0;
      pulse_setmin(47);
      chk("set_min59b", 32'(MIN), 59);
      ZeroSec = 1'b1;
      Run = 1'b1;
      step(1);
      ZeroSec = 1'b0;
      step(240);
      chk("clr_pre_hourup", 32'(HourUp), 1);
      chk("clr_pre_min", 32'(MIN), 0);
      #2;
      Clr = 1'b0;
      #1;
      chk("clr_hourup", 32'(HourUp), 0);
      chk("clr_tick", 32'(Tick), 0);
      chk("clr_sec", 32'(SEC), 0);
      chk("clr_min", 32'(MIN), 0);
      chk("clr_halfsec", 32'(HalfSec), 1);
      @(posedge Clk);
      #1;
      Clr = 1'b1;
      step(1);
      chk("post_clr_halfsec", 32'(HalfSec), 1);
      chk("post_clr_tick", 32'(Tick), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
